// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: packs MIPS field bundles into words and streams them into imem.
// Define INSTR_LOADER_CHECKSUM_EN to build the running XOR checksum of written words.
module instr_encoder_loader #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_fmt,
  input  logic [5:0]        in_op,
  input  logic [4:0]        in_sr1,
  input  logic [4:0]        in_sr2,
  input  logic [4:0]        in_dr,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_jump_addr,
  input  logic [5:0]        in_alu_func,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic [ADDR_W:0]   word_count,
  output logic [31:0]       checksum
);

  typedef enum logic [2:0] {
    IDLE, RUN, FULL, DRAIN, DONE
  } state_t;

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST = '1;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] rsv;
  logic              ent_v;
  logic [ADDR_W-1:0] ent_addr;
  logic [31:0]       ent_data;
  logic [31:0]       word;
  logic              acc, acc_ok, bad, wr_done;
  logic              full, empty;

  always_comb begin
    word = '0;
    unique case (in_fmt)
      2'd0: word = {in_op, in_sr1, in_sr2, in_dr,
                    5'b0, in_alu_func};
      2'd1: word = {in_op, in_sr1, in_sr2, in_imm};
      2'd2: word = {in_op, in_jump_addr};
      default: word = '0;
    endcase
  end

  // mem_* registers are the buffer head; ent_* is the second slot
  assign full     = mem_we && ent_v;
  assign empty    = !mem_we && !ent_v;
  assign in_ready = (state == RUN) && !full && !start;
  assign acc      = in_valid && in_ready;
  assign bad      = in_fmt == 2'd3;
  assign acc_ok   = acc && !bad;
  assign wr_done  = mem_we && mem_ready;

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = RUN;
    end else begin
      unique case (state)
        RUN: begin
          if (acc && in_last)
            state_nxt = DRAIN;
          else if (acc_ok && rsv == LAST)
            state_nxt = FULL;
        end
        FULL:  state_nxt = DRAIN;
        DRAIN: if (empty) state_nxt = DONE;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      ent_v      <= 1'b0;
      ent_addr   <= '0;
      ent_data   <= '0;
      rsv        <= BASE;
      word_count <= '0;
    end else begin
      state <= state_nxt;
      busy  <= state_nxt inside {RUN, FULL, DRAIN};
      done  <= state_nxt == DONE;
      if (start) begin
        mem_we     <= 1'b0;
        ent_v      <= 1'b0;
        rsv        <= BASE;
        word_count <= '0;
        err        <= '0;
      end else begin
        if (wr_done)
          word_count <= word_count + (ADDR_W+1)'(1);
        if (acc && bad)
          err[0] <= 1'b1;
        if (state == FULL && in_valid)
          err[1] <= 1'b1;
        if (acc_ok && rsv != LAST)
          rsv <= rsv + ADDR_W'(1);
        if (!mem_we || wr_done) begin
          if (ent_v) begin
            mem_we    <= 1'b1;
            mem_addr  <= ent_addr;
            mem_wdata <= ent_data;
            ent_v     <= acc_ok;
            if (acc_ok) begin
              ent_addr <= rsv;
              ent_data <= word;
            end
          end else if (acc_ok) begin
            mem_we    <= 1'b1;
            mem_addr  <= rsv;
            mem_wdata <= word;
          end else begin
            mem_we <= 1'b0;
          end
        end else if (acc_ok) begin
          ent_v    <= 1'b1;
          ent_addr <= rsv;
          ent_data <= word;
        end
      end
    end
  end

`ifdef INSTR_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      checksum <= '0;
    else if (start)
      checksum <= '0;
    else if (wr_done)
      checksum <= checksum ^ mem_wdata;
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: random sessions checked against a queue-based loader model.
// Checksum expectations follow INSTR_LOADER_CHECKSUM_EN when the bench is built with it.
module tb_instr_encoder_loader;

  localparam int AW  = 3;
  localparam int CAP = 1 << AW;

  typedef struct packed {
    logic [1:0]  fmt;
    logic [5:0]  op;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic [4:0]  d;
    logic [15:0] imm;
    logic [25:0] ja;
    logic [5:0]  fn;
  } bun_t;

  logic          clk = 0;
  logic          rst_n = 0;
  logic          start = 0;
  logic          busy, done;
  logic [1:0]    err;
  logic          in_valid = 0;
  logic          in_ready;
  logic [1:0]    in_fmt = 0;
  logic [5:0]    in_op = 0;
  logic [4:0]    in_sr1 = 0, in_sr2 = 0, in_dr = 0;
  logic [15:0]   in_imm = 0;
  logic [25:0]   in_jump_addr = 0;
  logic [5:0]    in_alu_func = 0;
  logic          in_last = 0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_ready = 0;
  logic [AW:0]   word_count;
  logic [31:0]   checksum;

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .busy(busy), .done(done), .err(err),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_op(in_op),
    .in_sr1(in_sr1), .in_sr2(in_sr2), .in_dr(in_dr),
    .in_imm(in_imm), .in_jump_addr(in_jump_addr),
    .in_alu_func(in_alu_func), .in_last(in_last),
    .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .word_count(word_count), .checksum(checksum)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pack(input bun_t b);
    logic [31:0] w;
    w = 32'(b.op) << 26;
    case (b.fmt)
      2'd0: w = w + (32'(b.s1) << 21) + (32'(b.s2) << 16)
              + (32'(b.d) << 11) + 32'(b.fn);
      2'd1: w = w + (32'(b.s1) << 21) + (32'(b.s2) << 16)
              + 32'(b.imm);
      default: w = w + 32'(b.ja);
    endcase
    return w;
  endfunction

  function automatic bun_t rnd_bun();
    bun_t b;
    b     = {$urandom, $urandom, $urandom};
    b.fmt = ($urandom_range(0, 9) == 0) ? 2'd3
          : 2'($urandom_range(0, 2));
    return b;
  endfunction

  function automatic bun_t mk(input logic [1:0] f,
                              input logic [5:0] op,
                              input logic [4:0] s1, s2, d,
                              input logic [15:0] imm,
                              input logic [25:0] ja,
                              input logic [5:0] fn);
    bun_t b;
    b = '{f, op, s1, s2, d, imm, ja, fn};
    return b;
  endfunction

  // Model state shared by driver and monitor
  bun_t        bq[$];
  logic [31:0] exp_q[$];
  int          pred_acc = 0;
  int          acc_n = 0, wr_n = 0, occ = 0;
  logic [31:0] cks = 0;
  bit          live = 0;
  int          rdy_mode = 0;
  int          rcyc = 0;

  always begin
    @(posedge clk);
    #2;
    if (start) rcyc = 0;
    else rcyc++;
    case (rdy_mode)
      1: mem_ready = $urandom_range(0, 9) < 7;
      2: mem_ready = 1'b1;
      3: mem_ready = $urandom_range(0, 3) == 0;
      4: mem_ready = rcyc > 6;
      default: mem_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (rst_n && start) begin
      check("start_prio", in_ready, 0);
      occ = 0; acc_n = 0; wr_n = 0; cks = 0;
      live = 1;
    end else if (rst_n && live) begin
      check("mem_we", mem_we, occ > 0);
      if (mem_we) begin
        check("wr_bound", wr_n < exp_q.size(), 1);
        check("mem_addr", mem_addr, wr_n);
        if (wr_n < exp_q.size())
          check("mem_wdata", mem_wdata, exp_q[wr_n]);
      end
      check("word_count", word_count, wr_n);
      check("checksum", checksum, cks);
      check("in_ready", in_ready,
            (acc_n < pred_acc) && (occ < 2));
      if (in_valid && in_ready) begin
        acc_n++;
        if (in_fmt != 2'd3) occ++;
      end
      if (mem_we && mem_ready) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
        if (wr_n < exp_q.size()) cks = cks ^ exp_q[wr_n];
`endif
        wr_n++;
        occ--;
      end
    end
  end

  task automatic chk_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_we"}, mem_we, 0);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_wdata"}, mem_wdata, 0);
    check({tag, "_wc"}, word_count, 0);
    check({tag, "_cks"}, checksum, 0);
    check({tag, "_rdy"}, in_ready, 0);
  endtask

  // abort: 0 full session, 1 leave stalled for next start, 2 async reset
  task automatic run_session(input int mode, input int abort);
    logic [1:0]  e_err;
    logic [31:0] words[$];
    logic [31:0] e_cks;
    int          pa, nacc;
    bit          gaps, ok;
    e_err = 0; pa = 0; nacc = 0; e_cks = 0;
    foreach (bq[i]) begin
      if (words.size() == CAP) begin
        e_err[1] = 1;
        break;
      end
      pa++;
      if (bq[i].fmt == 2'd3) e_err[0] = 1;
      else words.push_back(pack(bq[i]));
    end
    foreach (words[i]) e_cks = e_cks ^ words[i];
    gaps = !e_err[1];
    @(posedge clk); #1;
    rdy_mode = 0;
    start = 1;
    exp_q = words;
    pred_acc = pa;
    @(posedge clk); #1;
    start = 0;
    in_valid = 0;
    rdy_mode = mode;
    foreach (bq[i]) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 0;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      in_fmt = bq[i].fmt; in_op = bq[i].op;
      in_sr1 = bq[i].s1; in_sr2 = bq[i].s2;
      in_dr = bq[i].d; in_imm = bq[i].imm;
      in_jump_addr = bq[i].ja; in_alu_func = bq[i].fn;
      in_last = (i == bq.size() - 1);
      in_valid = 1;
      ok = 0;
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        if (in_ready) begin ok = 1; break; end
        if (done) break;
      end
      @(posedge clk); #1;
      if (!ok) break;
      nacc++;
      if (abort != 0 && nacc == 2) begin
        in_last = 0;
        repeat (3) @(posedge clk);
        #1;
        if (abort == 2) begin
          live = 0;
          rst_n = 0;
          #1;
          chk_zero("async_rst");
          @(posedge clk); #1;
          rst_n = 1;
          in_valid = 0;
        end
        return;
      end
    end
    in_valid = 0;
    in_last = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (done) break;
    end
    check("end_done", done, 1);
    check("end_busy", busy, 0);
    check("end_err", err, e_err);
    check("end_wc", word_count, words.size());
    check("end_accepted", nacc, pa);
    check("end_we", mem_we, 0);
`ifdef INSTR_LOADER_CHECKSUM_EN
    check("end_cks", checksum, e_cks);
`else
    check("end_cks", checksum, 0);
`endif
  endtask

  initial begin
    #12;
    chk_zero("reset");
    @(posedge clk); #1;
    rst_n = 1;

    bq = {mk(0, 0, 1, 2, 3, 0, 0, 6'h20)};
    run_session(2, 0);
    bq = {mk(1, 6'h08, 1, 2, 0, 16'hFFFF, 0, 0),
          mk(2, 6'h02, 0, 0, 0, 0, 26'h100, 0)};
    run_session(2, 0);
    bq = {mk(0, 1, 2, 3, 4, 0, 0, 5), mk(0, 6, 7, 8, 9, 0, 0, 10),
          mk(0, 11, 12, 13, 14, 0, 0, 15)};
    run_session(4, 0);
    bq = {mk(0, 0, 1, 2, 3, 0, 0, 6'h20),
          mk(3, 6'h3F, 31, 31, 31, 16'hFFFF, '1, '1),
          mk(0, 0, 4, 5, 6, 0, 0, 6'h22)};
    run_session(2, 0);
    bq.delete();
    for (int i = 0; i < CAP + 2; i++)
      bq.push_back(mk(1, 6'(i), 5'(i), 5'(i + 1), 0,
                      16'(i * 77), 0, 0));
    run_session(2, 0);
    bq = {mk(0, 1, 1, 1, 1, 0, 0, 1), mk(1, 2, 2, 2, 0, 2, 0, 0),
          mk(2, 3, 0, 0, 0, 0, 3, 0)};
    run_session(0, 1);
    bq = {mk(0, 0, 1, 2, 3, 0, 0, 6'h20),
          mk(1, 6'h08, 1, 2, 0, 16'hFFFF, 0, 0)};
    run_session(1, 0);

    for (int s = 0; s < 30; s++) begin
      int n, ab;
      n = $urandom_range(1, CAP + 4);
      bq.delete();
      for (int i = 0; i < n; i++) bq.push_back(rnd_bun());
      ab = (n >= 3 && $urandom_range(0, 5) == 0)
         ? $urandom_range(1, 2) : 0;
      run_session(ab != 0 ? 0 : $urandom_range(1, 4), ab);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
